// File: rtl/bmp180_pkg.sv
// bmp180_pkg: sequencer states, BMP180 command codes and the code-to-conversion-delay map.
package bmp180_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_CALIB = 8'hAA;
    localparam logic [7:0] CMD_TEMP  = 8'h2E;
    localparam logic [7:0] CMD_P0    = 8'h34;
    localparam logic [7:0] CMD_P1    = 8'h74;
    localparam logic [7:0] CMD_P2    = 8'hB4;
    localparam logic [7:0] CMD_P3    = 8'hF4;
    localparam logic [7:0] CMD_RESET = 8'hB6;
    localparam logic [7:0] CMD_ID    = 8'hD0;

    // Conversion time in 0.5 ms units; zero means the command completes without waiting.
    function automatic logic [5:0] conv_delay(input logic [7:0] code);
        case (code)
            CMD_TEMP, CMD_P0: return 6'd9;
            CMD_P1:           return 6'd15;
            CMD_P2:           return 6'd27;
            CMD_P3:           return 6'd51;
            default:          return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/bmp180_tick_gen.sv
// bmp180_tick_gen: half-millisecond prescaler, pulses tick once every HALF_MS enabled cycles.
module bmp180_tick_gen #(
    parameter int HALF_MS = 25_000
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = HALF_MS > 1 ? $clog2(HALF_MS) : 1;

    logic [PW-1:0] r_cnt;

    assign tick = enable && r_cnt == PW'(HALF_MS - 1);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/bmp180_cmd_seq.sv
// bmp180_cmd_seq: fetches a command byte from the ROM, hands it to the I2C master,
// then times the sensor conversion delay before reporting completion.
module bmp180_cmd_seq
    import bmp180_pkg::*;
#(
    parameter int ADDR_ROM_SZ = 4,
    parameter int DATA_ROM_SZ = 8,
    parameter int CLK_HZ      = 50_000_000
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   I_START,
    input  logic [ADDR_ROM_SZ-1:0] I_CMD_IDX,
    output logic                   O_BUSY,
    output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM,
    input  logic [ADDR_ROM_SZ-1:0] I_ADDR_ROM,
    input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM,
    output logic [DATA_ROM_SZ-1:0] O_CMD,
    output logic                   O_CMD_VLD,
    input  logic                   I_CMD_RDY,
    output logic                   O_CONV,
    output logic                   O_DONE,
    output logic                   O_ERR
);

    localparam int HALF_MS = CLK_HZ / 2000;

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_ROM_SZ-1:0] r_addr_rom;
    logic [DATA_ROM_SZ-1:0] r_cmd;
    logic [5:0]             r_units;
    logic [5:0]             w_delay;
    logic                   w_match;
    logic                   w_wait;
    logic                   w_tick;
    logic                   w_last;

    assign w_match = I_ADDR_ROM == r_addr_rom;
    assign w_delay = conv_delay(8'(r_cmd));
    assign w_wait  = r_state == ST_WAIT;
    assign w_last  = w_tick && r_units == w_delay - 6'd1;

    // Prescaler held cleared outside WAIT so every delay starts on a fresh half-ms phase.
    bmp180_tick_gen #(
        .HALF_MS(HALF_MS)
    ) u_tick (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clear (!w_wait),
        .enable(w_wait),
        .tick  (w_tick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = I_START ? ST_FETCH : ST_IDLE;
            ST_FETCH: w_next = ST_LATCH;
            ST_LATCH: w_next = w_match ? ST_SEND : ST_IDLE;
            ST_SEND:  w_next = !I_CMD_RDY ? ST_SEND : (w_delay != 6'd0) ? ST_WAIT : ST_DONE;
            ST_WAIT:  w_next = w_last ? ST_DONE : ST_WAIT;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state    <= ST_IDLE;
            r_addr_rom <= '0;
            r_cmd      <= '0;
            r_units    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && I_START)
                r_addr_rom <= I_CMD_IDX;
            if (r_state == ST_LATCH && w_match)
                r_cmd <= I_DATA_ROM;
            r_units <= !w_wait ? 6'd0 : w_tick ? r_units + 6'd1 : r_units;
        end
    end

    assign O_ADDR_ROM = r_addr_rom;
    assign O_CMD      = r_cmd;
    assign O_BUSY     = r_state != ST_IDLE;
    assign O_CMD_VLD  = r_state == ST_SEND;
    assign O_CONV     = w_wait;
    assign O_DONE     = r_state == ST_DONE;
    // Error is flagged in the LATCH cycle itself so busy falls the cycle after it.
    assign O_ERR      = r_state == ST_LATCH && !w_match;

endmodule
